task1_cpu_cpu_ocimem_arbiter: RTL and testbench
===============================================

Name: task1_cpu_cpu_ocimem_arbiter

Overview:
- Shares the CPU's single-port on-chip debug memory (OCI RAM) between two requesters.
- Requester 0 is the JTAG debug-slave action path, which delivers single-cycle strobes in the clk domain and cannot be back-pressured.
- Requester 1 is the CPU's Avalon-style debug-mode access port, which is stalled with waitrequest.
- Owns the JTAG address pointer, MonDReg capture and the monitor_ready/monitor_error status returned to the debug slave.

Parameters:
- ADDR_W, 8, OCI RAM word-address width (depth 2^ADDR_W x 32 bit).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jtag_ld_addr  in  1  strobe: pointer <= jtag_data[ADDR_W-1:0]
- jtag_rd  in  1  strobe: read RAM at pointer, then post-increment pointer
- jtag_wr  in  1  strobe: write jtag_data[31:0] at pointer, then post-increment pointer
- jtag_data  in  38  JTAG shift-register payload (jdo)
- jtag_clr_err  in  1  strobe: clear monitor_error
- MonDReg  out  32  data from the last JTAG read
- monitor_ready  out  1  no JTAG operation pending or in flight
- monitor_error  out  1  sticky JTAG command error
- cpu_read  in  1  CPU read request
- cpu_write  in  1  CPU write request
- cpu_address  in  ADDR_W  CPU word address
- cpu_writedata  in  32  CPU write data
- cpu_byteenable  in  4  CPU byte enables
- cpu_waitrequest  out  1  stall CPU
- cpu_readdata  out  32  CPU read data, valid when read and ~waitrequest
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM write data
- ram_be  out  4  RAM byte enables (JTAG writes use 4'hF)
- ram_we  out  1  RAM write enable
- ram_rdata  in  32  RAM read data, 1-cycle latency

Behaviour:
- Reset (async, reset_n low):
  - state IDLE, pointer 0, pend_valid 0, last_grant = CPU.
  - MonDReg 0, monitor_ready 1, monitor_error 0.
  - ram_we 0; cpu_waitrequest = cpu_read|cpu_write.
  - Reset mid-operation aborts the operation with no RAM write; the CPU must re-issue.
- JTAG capture:
  - A jtag_rd or jtag_wr strobe loads a 1-deep pending register {is_wr, data} on the next edge and sets pend_valid.
  - monitor_ready is registered: it falls on the edge that captures the strobe.
  - A strobe arriving in the cycle pend_valid is cleared by its grant is accepted.
  - A strobe arriving while pend_valid stays set is dropped and sets monitor_error.
  - More than one of ld_addr/rd/wr in the same cycle: all are ignored and monitor_error is set.
  - jtag_ld_addr takes effect on the next edge and never touches the RAM.
  - jtag_clr_err clears monitor_error; if a new error occurs in the same cycle, the error wins.
- FSM states:
  - IDLE: arbitrate between the JTAG request (pend_valid) and the CPU request (cpu_read|cpu_write).
    - If both request, grant the requester opposite last_grant; otherwise grant the sole requester.
    - The grant updates last_grant.
    - JTAG write: ram_addr = pointer, ram_we = 1; pointer++; pend_valid cleared; monitor_ready set next edge; stay in IDLE.
    - JTAG read: ram_addr = pointer; pointer++; pend_valid cleared; go to JRD.
    - CPU write: RAM driven from the cpu_* inputs with ram_we = 1; cpu_waitrequest = 0 this cycle; stay in IDLE.
    - CPU read: ram_addr = cpu_address; cpu_waitrequest = 1; go to CRD.
  - JRD: MonDReg <= ram_rdata and monitor_ready <= 1 on the exiting edge; return to IDLE. No RAM access in this cycle.
  - CRD: cpu_readdata = ram_rdata and cpu_waitrequest = 0; return to IDLE.
- Latency:
  - CPU write: 1 cycle when granted immediately.
  - CPU read: 2 cycles.
  - JTAG read: strobe to MonDReg valid is 3 edges when uncontended.
- Pointer wraps from 2^ADDR_W-1 to 0.
- cpu_waitrequest = (cpu_read|cpu_write) & ~completing-this-cycle. It is 0 when the CPU has no request.
- cpu_readdata is held at its last value outside CRD.
- The CPU must hold address/data stable while waitrequest is high.

Decomposition:
- Shared package task1_cpu_ocimem_pkg holds:
  - FSM state enum (IDLE, JRD, CRD).
  - Grant-owner constants (GNT_JTAG, GNT_CPU).
  - Default ADDR_W.
- No sub-module; the round-robin choice is small enough to stay inline.

Test Plan:
- Reset, then jtag_ld_addr with data 0x10, jtag_wr data 0xDEADBEEF, then jtag_rd at 0x10 -> RAM[0x10] = 0xDEADBEEF; pointer reaches 0x12; MonDReg reads back the written word; monitor_ready is 0 between strobe capture and MonDReg update.
- CPU write 0x12345678 with be 4'b0011 to addr 5, then CPU read addr 5 -> write has waitrequest 0 in the first cycle; read waitrequest is high 1 cycle; readdata shows the low halfword updated.
- JTAG pending and CPU read asserted in the same cycle after reset -> JTAG granted first (last_grant = CPU); CPU granted next; alternation continues under sustained contention.
- jtag_rd followed by a second jtag_rd while pend_valid=1 and the CPU holds the arbiter -> second strobe dropped; monitor_error=1 until jtag_clr_err; only one pointer increment.
- Pointer at 0xFF, then jtag_wr -> writes 0xFF and pointer becomes 0x00; jtag_rd and jtag_wr in the same cycle -> no RAM access, monitor_error=1.
- reset_n asserted while in CRD -> state IDLE, ram_we 0, monitor_ready 1; CPU re-issues after reset and completes normally.

Source files
------------

// File: rtl/task1_cpu_ocimem_pkg.sv
// Shared types and constants for the OCI RAM arbiter between the JTAG debug
// slave and the CPU debug-mode access port.
package task1_cpu_ocimem_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JRD  = 2'd1,
        CRD  = 2'd2
    } state_e;

    localparam logic GNT_JTAG = 1'b0;
    localparam logic GNT_CPU  = 1'b1;

    // Round-robin pick: with both requesting, the side that did not win last goes.
    function automatic logic pick_owner(input logic last_grant,
                                        input logic jtag_req,
                                        input logic cpu_req);
        logic owner;
        if (jtag_req && cpu_req) begin
            owner = (last_grant == GNT_CPU) ? GNT_JTAG : GNT_CPU;
        end else if (jtag_req) begin
            owner = GNT_JTAG;
        end else begin
            owner = GNT_CPU;
        end
        return owner;
    endfunction

endpackage

// File: rtl/task1_cpu_cpu_ocimem_arbiter.sv
// Single-port OCI RAM arbiter: JTAG action strobes (1-deep pending, never
// stalled) versus the CPU debug port (stalled via waitrequest).
module task1_cpu_cpu_ocimem_arbiter
    import task1_cpu_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_ld_addr,
    input  logic              jtag_rd,
    input  logic              jtag_wr,
    input  logic [37:0]       jtag_data,
    input  logic              jtag_clr_err,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_next_s;
    logic              pend_valid_q, pend_valid_d;
    logic              pend_wr_q, pend_wr_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic              mon_ready_q, mon_ready_d;
    logic              mon_error_q, mon_error_d;
    logic [31:0]       rdata_hold_q, rdata_hold_d;

    logic              cpu_req_s, jgrant_s, cpu_done_s;
    logic              multi_s, accept_s, drop_s, ld_ok_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [31:0]       ram_wdata_s, rdata_s;
    logic [3:0]        ram_be_s;
    logic              ram_we_s;
    logic              unused_s;

    assign cpu_req_s = cpu_read | cpu_write;
    assign unused_s  = ^jtag_data[37:32];

    // Arbitration, RAM port drive and FSM next state.
    always_comb begin
        state_d      = state_q;
        ptr_next_s   = ptr_q;
        last_grant_d = last_grant_q;
        jgrant_s     = 1'b0;
        cpu_done_s   = 1'b0;
        ram_addr_s   = ptr_q;
        ram_wdata_s  = 32'd0;
        ram_be_s     = 4'd0;
        ram_we_s     = 1'b0;
        mon_dreg_d   = mon_dreg_q;
        rdata_hold_d = rdata_hold_q;
        rdata_s      = rdata_hold_q;
        case (state_q)
            IDLE: begin
                if (pend_valid_q &&
                    (pick_owner(last_grant_q, pend_valid_q, cpu_req_s) == GNT_JTAG)) begin
                    jgrant_s     = 1'b1;
                    last_grant_d = GNT_JTAG;
                    ptr_next_s   = ptr_q + ADDR_W'(1);
                    if (pend_wr_q) begin
                        ram_we_s    = 1'b1;
                        ram_wdata_s = pend_data_q;
                        ram_be_s    = 4'hF;
                    end else begin
                        state_d = JRD;
                    end
                end else if (cpu_req_s) begin
                    last_grant_d = GNT_CPU;
                    ram_addr_s   = cpu_address;
                    if (cpu_write) begin
                        ram_we_s    = 1'b1;
                        ram_wdata_s = cpu_writedata;
                        ram_be_s    = cpu_byteenable;
                        cpu_done_s  = 1'b1;
                    end else begin
                        state_d = CRD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            JRD: begin
                mon_dreg_d = ram_rdata;
                state_d    = IDLE;
            end
            CRD: begin
                ram_addr_s   = cpu_address;
                rdata_s      = ram_rdata;
                rdata_hold_d = ram_rdata;
                cpu_done_s   = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // JTAG strobe capture, pointer load and sticky error bookkeeping.
    always_comb begin
        multi_s  = (jtag_ld_addr & jtag_rd) | (jtag_ld_addr & jtag_wr) | (jtag_rd & jtag_wr);
        ld_ok_s  = jtag_ld_addr & ~multi_s;
        accept_s = (jtag_rd | jtag_wr) & ~multi_s & (~pend_valid_q | jgrant_s);
        drop_s   = (jtag_rd | jtag_wr) & ~multi_s & pend_valid_q & ~jgrant_s;

        ptr_d = ld_ok_s ? jtag_data[ADDR_W-1:0] : ptr_next_s;

        if (accept_s) begin
            pend_valid_d = 1'b1;
            pend_wr_d    = jtag_wr;
            pend_data_d  = jtag_data[31:0];
        end else begin
            pend_valid_d = jgrant_s ? 1'b0 : pend_valid_q;
            pend_wr_d    = pend_wr_q;
            pend_data_d  = pend_data_q;
        end

        if (multi_s | drop_s) begin
            mon_error_d = 1'b1;
        end else if (jtag_clr_err) begin
            mon_error_d = 1'b0;
        end else begin
            mon_error_d = mon_error_q;
        end

        // Ready means nothing waiting and no read in flight after this edge.
        mon_ready_d = ~(pend_valid_d | (state_d == JRD));
    end

    // State and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= {ADDR_W{1'b0}};
            pend_valid_q <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_data_q  <= 32'd0;
            last_grant_q <= GNT_CPU;
            mon_dreg_q   <= 32'd0;
            mon_ready_q  <= 1'b1;
            mon_error_q  <= 1'b0;
            rdata_hold_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pend_valid_q <= pend_valid_d;
            pend_wr_q    <= pend_wr_d;
            pend_data_q  <= pend_data_d;
            last_grant_q <= last_grant_d;
            mon_dreg_q   <= mon_dreg_d;
            mon_ready_q  <= mon_ready_d;
            mon_error_q  <= mon_error_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    // The RAM port and CPU handshake must answer in the granting cycle, so
    // they stay combinational; reset suppresses any write or completion.
    assign ram_addr        = ram_addr_s;
    assign ram_wdata       = ram_wdata_s;
    assign ram_be          = ram_be_s;
    assign ram_we          = ram_we_s & reset_n;
    assign cpu_waitrequest = cpu_req_s & ~(cpu_done_s & reset_n);
    assign cpu_readdata    = rdata_s;
    assign MonDReg         = mon_dreg_q;
    assign monitor_ready   = mon_ready_q;
    assign monitor_error   = mon_error_q;

endmodule

// File: tb/tb_task1_cpu_cpu_ocimem_arbiter.sv
// Self-checking bench: behavioural RAM plus a word-level memory/pointer model.
module tb_task1_cpu_cpu_ocimem_arbiter;

    logic        clk, reset_n;
    logic        jtag_ld_addr, jtag_rd, jtag_wr, jtag_clr_err;
    logic [37:0] jtag_data;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic        cpu_read, cpu_write, cpu_waitrequest;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata, cpu_readdata;
    logic [3:0]  cpu_byteenable;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic        ram_we;

    logic [31:0] tb_mem  [0:255];
    logic [31:0] ref_mem [0:255];
    logic [7:0]  exp_ptr;
    int          tests_run = 0;
    int          tests_failed = 0;

    task1_cpu_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .jtag_ld_addr(jtag_ld_addr), .jtag_rd(jtag_rd), .jtag_wr(jtag_wr),
        .jtag_data(jtag_data), .jtag_clr_err(jtag_clr_err),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) tb_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= tb_mem[ram_addr];
    end

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~m) | (new_w & m);
    endfunction

    task automatic idle_inputs();
        jtag_ld_addr = 1'b0; jtag_rd = 1'b0; jtag_wr = 1'b0; jtag_clr_err = 1'b0;
        jtag_data = 38'd0; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_address = 8'd0; cpu_writedata = 32'd0; cpu_byteenable = 4'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        exp_ptr = 8'd0;
        @(negedge clk);
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bit done = 1'b0;
        cpu_write = 1'b1; cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
        for (int n = 0; n < 20 && !done; n++) begin
            #1; if (!cpu_waitrequest) done = 1'b1;
            @(negedge clk);
        end
        cpu_write = 1'b0;
        if (done) ref_mem[a] = merge_be(ref_mem[a], d, be);
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL cpu_wr_timeout addr=%0h got waitrequest stuck, need completion", a); end
    endtask

    task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d);
        bit done = 1'b0;
        d = 32'd0;
        cpu_read = 1'b1; cpu_address = a;
        for (int n = 0; n < 20 && !done; n++) begin
            #1; if (!cpu_waitrequest) begin done = 1'b1; d = cpu_readdata; end
            @(negedge clk);
        end
        cpu_read = 1'b0;
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL cpu_rd_timeout addr=%0h got waitrequest stuck, need completion", a); end
    endtask

    // kind: 0 = load pointer, 1 = read, 2 = write.
    task automatic jtag_cmd(input int kind, input logic [37:0] d);
        bit done = 1'b0;
        jtag_data = d;
        jtag_ld_addr = (kind == 0); jtag_rd = (kind == 1); jtag_wr = (kind == 2);
        @(negedge clk);
        jtag_ld_addr = 1'b0; jtag_rd = 1'b0; jtag_wr = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            #1; if (monitor_ready) done = 1'b1;
            @(negedge clk);
        end
        if (kind == 0) exp_ptr = d[7:0];
        else begin
            if (kind == 2) ref_mem[exp_ptr] = d[31:0];
            exp_ptr = exp_ptr + 8'd1;
        end
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL jtag_cmd_timeout kind=%0d got ready=0, need 1", kind); end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        cpu_read = 1'b1;
        @(negedge clk); #1;
        tests_run++;
        if (monitor_ready !== 1'b1 || monitor_error !== 1'b0 || MonDReg !== 32'd0 ||
            ram_we !== 1'b0 || cpu_waitrequest !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state got rdy=%b err=%b mon=%h we=%b wait=%b, need 1 0 0 0 1",
                     monitor_ready, monitor_error, MonDReg, ram_we, cpu_waitrequest);
        end
        cpu_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_ptr = 8'd0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hXXXX_XXXX;
        for (int i = 0; i < 256; i++) cpu_wr(i[7:0], 32'd0, 4'hF);
    endtask

    task automatic test_jtag_basic();
        jtag_cmd(0, 38'h10);
        jtag_cmd(2, 38'hDEADBEEF);
        tests_run++;
        if (tb_mem[8'h10] !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL jtag_write got mem[10]=%h, need deadbeef", tb_mem[8'h10]);
        end
        jtag_cmd(0, 38'h10);
        jtag_data = 38'd0; jtag_rd = 1'b1;
        @(negedge clk); jtag_rd = 1'b0; #1;
        tests_run++;
        if (monitor_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_after_capture got %b, need 0", monitor_ready); end
        @(negedge clk); #1;
        tests_run++;
        if (monitor_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_in_flight got %b, need 0", monitor_ready); end
        @(negedge clk); #1;
        tests_run++;
        if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL jtag_read_3edges got rdy=%b mon=%h, need 1 deadbeef", monitor_ready, MonDReg);
        end
        exp_ptr = 8'h11;
        @(negedge clk);
        jtag_cmd(2, 38'h0BADF00D);
        jtag_cmd(2, 38'hCAFE0012);
        tests_run++;
        if (tb_mem[8'h11] !== 32'h0BADF00D || tb_mem[8'h12] !== 32'hCAFE0012) begin
            tests_failed++; $display("FAIL pointer_advance got mem[11]=%h mem[12]=%h, need 0badf00d cafe0012",
                                     tb_mem[8'h11], tb_mem[8'h12]);
        end
    endtask

    task automatic test_cpu_basic();
        cpu_address = 8'd5; cpu_writedata = 32'h12345678; cpu_byteenable = 4'b0011; cpu_write = 1'b1;
        #1;
        tests_run++;
        if (cpu_waitrequest !== 1'b0) begin tests_failed++; $display("FAIL cpu_write_wait got %b, need 0", cpu_waitrequest); end
        @(negedge clk);
        cpu_write = 1'b0;
        ref_mem[5] = merge_be(ref_mem[5], 32'h12345678, 4'b0011);
        cpu_read = 1'b1; #1;
        tests_run++;
        if (cpu_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL cpu_read_wait1 got %b, need 1", cpu_waitrequest); end
        @(negedge clk); #1;
        tests_run++;
        if (cpu_waitrequest !== 1'b0 || cpu_readdata !== 32'h00005678) begin
            tests_failed++; $display("FAIL cpu_read_data got wait=%b data=%h, need 0 00005678", cpu_waitrequest, cpu_readdata);
        end
        @(negedge clk);
        cpu_read = 1'b0; #1;
        tests_run++;
        if (cpu_readdata !== 32'h00005678) begin tests_failed++; $display("FAIL readdata_hold got %h, need 00005678", cpu_readdata); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int          last, winner, expw;
        logic [31:0] pend_val, cdata;
        logic [7:0]  caddr;
        bit          cpu_adv, done;
        apply_reset();
        jtag_cmd(0, 38'h40);
        pend_val = 32'hA000_0000;
        jtag_data = {6'd0, pend_val}; jtag_wr = 1'b1;
        @(negedge clk);
        jtag_wr = 1'b0;
        last = 1; caddr = 8'h50; cdata = 32'h0000_00C0; cpu_adv = 1'b0;
        cpu_address = caddr; cpu_writedata = cdata; cpu_byteenable = 4'b0001; cpu_write = 1'b1;
        for (int k = 0; k < 8; k++) begin
            jtag_wr = 1'b0;
            if (cpu_adv) begin
                caddr = caddr + 8'd1; cdata = cdata + 32'd1;
                cpu_address = caddr; cpu_writedata = cdata; cpu_adv = 1'b0;
            end
            #1;
            winner = !ram_we ? 2 : (ram_be == 4'hF) ? 0 : (ram_be == 4'b0001) ? 1 : 2;
            expw = 1 - last;
            tests_run++;
            if (winner != expw) begin
                tests_failed++; $display("FAIL rr_grant cycle=%0d got owner=%0d, need %0d", k, winner, expw);
            end
            last = expw;
            if (winner == 0) begin
                tests_run++;
                if (ram_addr !== exp_ptr || cpu_waitrequest !== 1'b1) begin
                    tests_failed++; $display("FAIL rr_jtag_port got addr=%h wait=%b, need %h 1", ram_addr, cpu_waitrequest, exp_ptr);
                end
                ref_mem[exp_ptr] = pend_val; exp_ptr = exp_ptr + 8'd1;
                pend_val = pend_val + 32'd1;
                jtag_data = {6'd0, pend_val}; jtag_wr = 1'b1;
            end else if (winner == 1) begin
                ref_mem[caddr] = merge_be(ref_mem[caddr], cdata, 4'b0001);
                cpu_adv = 1'b1;
            end
            @(negedge clk);
        end
        jtag_wr = 1'b0; cpu_write = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin #1; if (monitor_ready) done = 1'b1; @(negedge clk); end
        ref_mem[exp_ptr] = pend_val; exp_ptr = exp_ptr + 8'd1;
        tests_run++;
        if (!done || monitor_error !== 1'b0) begin
            tests_failed++; $display("FAIL rr_drain got ready=%b err=%b, need 1 0", done, monitor_error);
        end
    endtask

    task automatic test_drop_error();
        logic [31:0] d;
        bit          done = 1'b0;
        jtag_cmd(0, 38'h20);
        cpu_address = 8'd3; cpu_read = 1'b1; jtag_data = 38'd0; jtag_rd = 1'b1;
        @(negedge clk); #1;
        d = cpu_readdata;
        tests_run++;
        if (cpu_waitrequest !== 1'b0 || d !== ref_mem[3]) begin
            tests_failed++; $display("FAIL drop_cpu_read got wait=%b data=%h, need 0 %h", cpu_waitrequest, d, ref_mem[3]);
        end
        @(negedge clk);
        cpu_read = 1'b0; jtag_rd = 1'b0; #1;
        tests_run++;
        if (monitor_error !== 1'b1 || monitor_ready !== 1'b0) begin
            tests_failed++; $display("FAIL drop_error got err=%b rdy=%b, need 1 0", monitor_error, monitor_ready);
        end
        for (int n = 0; n < 20 && !done; n++) begin #1; if (monitor_ready) done = 1'b1; @(negedge clk); end
        exp_ptr = 8'h21;
        tests_run++;
        if (!done || MonDReg !== ref_mem[8'h20] || monitor_error !== 1'b1) begin
            tests_failed++; $display("FAIL drop_read got rdy=%b mon=%h err=%b, need 1 %h 1", done, MonDReg, monitor_error, ref_mem[8'h20]);
        end
        jtag_clr_err = 1'b1;
        @(negedge clk);
        jtag_clr_err = 1'b0; #1;
        tests_run++;
        if (monitor_error !== 1'b0) begin tests_failed++; $display("FAIL clr_err got %b, need 0", monitor_error); end
        @(negedge clk);
        jtag_cmd(2, 38'h5A5A0021);
        tests_run++;
        if (tb_mem[8'h21] !== 32'h5A5A0021 || tb_mem[8'h22] !== ref_mem[8'h22]) begin
            tests_failed++; $display("FAIL drop_single_inc got mem[21]=%h, need 5a5a0021", tb_mem[8'h21]);
        end
    endtask

    task automatic test_wrap_multi();
        bit we_seen = 1'b0;
        jtag_cmd(0, 38'hFF);
        jtag_cmd(2, 38'h111100FF);
        jtag_cmd(2, 38'h22220000);
        tests_run++;
        if (tb_mem[8'hFF] !== 32'h111100FF || tb_mem[8'h00] !== 32'h22220000) begin
            tests_failed++; $display("FAIL ptr_wrap got mem[ff]=%h mem[0]=%h, need 111100ff 22220000", tb_mem[8'hFF], tb_mem[8'h00]);
        end
        jtag_data = 38'h3333_0001; jtag_rd = 1'b1; jtag_wr = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1; if (ram_we) we_seen = 1'b1;
            @(negedge clk);
            jtag_rd = 1'b0; jtag_wr = 1'b0;
        end
        tests_run++;
        if (we_seen || monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin
            tests_failed++; $display("FAIL multi_strobe got we=%b err=%b rdy=%b, need 0 1 1", we_seen, monitor_error, monitor_ready);
        end
        jtag_clr_err = 1'b1; @(negedge clk); jtag_clr_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        cpu_address = 8'd7; cpu_read = 1'b1;
        @(negedge clk); #1;
        reset_n = 1'b0; #1;
        tests_run++;
        if (cpu_waitrequest !== 1'b1 || ram_we !== 1'b0 || monitor_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_crd got wait=%b we=%b rdy=%b, need 1 0 1", cpu_waitrequest, ram_we, monitor_ready);
        end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1; exp_ptr = 8'd0;
        cpu_rd(8'd7, d);
        tests_run++;
        if (d !== ref_mem[7]) begin tests_failed++; $display("FAIL reissue_read got %h, need %h", d, ref_mem[7]); end
    endtask

    task automatic test_random();
        logic [31:0] d, expd;
        logic [7:0]  a;
        int          mism = 0;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 3))
                0: cpu_wr(a, $urandom, 4'($urandom_range(1, 15)));
                1: begin
                    cpu_rd(a, d);
                    tests_run++;
                    if (d !== ref_mem[a]) begin tests_failed++; $display("FAIL rand_cpu_rd addr=%h got %h, need %h", a, d, ref_mem[a]); end
                end
                2: begin
                    jtag_cmd(0, {6'($urandom), 24'd0, a});
                    jtag_cmd(2, {6'($urandom), 32'($urandom)});
                end
                default: begin
                    jtag_cmd(0, {30'd0, a});
                    expd = ref_mem[a];
                    jtag_cmd(1, {6'($urandom), 32'($urandom)});
                    tests_run++;
                    if (MonDReg !== expd) begin tests_failed++; $display("FAIL rand_jtag_rd addr=%h got %h, need %h", a, MonDReg, expd); end
                end
            endcase
        end
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
        tests_run++;
        if (mism != 0) begin tests_failed++; $display("FAIL final_memory got %0d differing words, need 0", mism); end
    endtask

    initial begin
        test_reset();
        test_jtag_basic();
        test_cpu_basic();
        test_contention();
        test_drop_error();
        test_wrap_multi();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
